// File: rtl/cnt_mod_bcd.sv
// Two-digit BCD modulo-MOD counter with up/down stepping, guarded preset and
// carry/terminal-count flags for zero-latency cascading of clock stages.
module cnt_mod_bcd #(
  parameter int MOD = 60
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CLR,
  input  logic       EN,
  input  logic       INC,
  input  logic       DN,
  input  logic       LD,
  input  logic [3:0] DH,
  input  logic [3:0] DL,
  output logic [3:0] QH,
  output logic [3:0] QL,
  output logic       CA,
  output logic       TC
);

  localparam logic [3:0] TH_LIM = 4'((MOD - 1) / 10);
  localparam logic [3:0] TL_LIM = 4'((MOD - 1) % 10);
  localparam logic [7:0] TOP    = 8'(MOD - 1);

  logic [3:0] qh_p0;
  logic [3:0] ql_p0;
  logic       at_top;
  logic       at_zero;
  logic       step;
  logic [7:0] nxt_up;
  logic [7:0] nxt_dn;

  function automatic logic [7:0] bcd_up(input logic [3:0] h, input logic [3:0] l);
    logic [7:0] r;
    if (h == TH_LIM && l == TL_LIM)
      r = 8'h00;
    else if (l == 4'd9)
      r = {h + 4'd1, 4'd0};
    else
      r = {h, l + 4'd1};
    return r;
  endfunction

  function automatic logic [7:0] bcd_dn(input logic [3:0] h, input logic [3:0] l);
    logic [7:0] r;
    if (h == 4'd0 && l == 4'd0)
      r = {TH_LIM, TL_LIM};
    else if (l == 4'd0)
      r = {h - 4'd1, 4'd9};
    else
      r = {h, l - 4'd1};
    return r;
  endfunction

  // Both digits must be BCD and the binary value must sit inside 0..MOD-1.
  function automatic logic preset_ok(input logic [3:0] h, input logic [3:0] l);
    logic [7:0] v;
    v = 8'(h) * 8'd10 + 8'(l);
    return (h <= 4'd9) && (l <= 4'd9) && (v <= TOP);
  endfunction

  always_comb begin
    at_top  = (qh_p0 == TH_LIM) && (ql_p0 == TL_LIM);
    at_zero = (qh_p0 == 4'd0) && (ql_p0 == 4'd0);
    step    = EN | INC;
    nxt_up  = bcd_up(qh_p0, ql_p0);
    nxt_dn  = bcd_dn(qh_p0, ql_p0);
    TC      = DN ? at_zero : at_top;
    // Only the enable tick may carry; manual INC and any overriding control mask it.
    CA      = EN & TC & ~LD & ~CLR & RST;
  end

  // Stage p0: digit state register
  always_ff @(posedge CLK) begin
    if (!RST) begin
      qh_p0 <= 4'd0;
      ql_p0 <= 4'd0;
    end else if (CLR) begin
      qh_p0 <= 4'd0;
      ql_p0 <= 4'd0;
    end else if (LD) begin
      if (preset_ok(DH, DL)) begin
        qh_p0 <= DH;
        ql_p0 <= DL;
      end
    end else if (step) begin
      {qh_p0, ql_p0} <= DN ? nxt_dn : nxt_up;
    end
  end

  assign QH = qh_p0;
  assign QL = ql_p0;

endmodule

// File: tb/tb_cnt_mod_bcd.sv
// Directed bench for cnt_mod_bcd: vector table on a MOD=60 instance plus
// wrap sequences for MOD=60/24/100 and a 60-into-24 cascade.
module tb_cnt_mod_bcd;

  logic       clk = 1'b0;
  logic       rst, clr, en, inc, dn, ld;
  logic [3:0] dh, dl;

  logic [3:0] qh60, ql60, qh24, ql24, qh100, ql100;
  logic       ca60, tc60, ca24, tc24, ca100, tc100;

  logic       c_rst, c_en, c_zero;
  logic [3:0] c_dz;
  logic [3:0] lo_qh, lo_ql, hi_qh, hi_ql;
  logic       lo_ca, lo_tc, hi_ca, hi_tc;

  int checks = 0;
  int errors = 0;
  int sel    = 0;

  logic [3:0] s_qh, s_ql;
  logic       s_ca, s_tc;

  always #5 clk = ~clk;

  cnt_mod_bcd #(.MOD(60)) dut60 (
    .CLK(clk), .RST(rst), .CLR(clr), .EN(en), .INC(inc), .DN(dn), .LD(ld),
    .DH(dh), .DL(dl), .QH(qh60), .QL(ql60), .CA(ca60), .TC(tc60));

  cnt_mod_bcd #(.MOD(24)) dut24 (
    .CLK(clk), .RST(rst), .CLR(clr), .EN(en), .INC(inc), .DN(dn), .LD(ld),
    .DH(dh), .DL(dl), .QH(qh24), .QL(ql24), .CA(ca24), .TC(tc24));

  cnt_mod_bcd #(.MOD(100)) dut100 (
    .CLK(clk), .RST(rst), .CLR(clr), .EN(en), .INC(inc), .DN(dn), .LD(ld),
    .DH(dh), .DL(dl), .QH(qh100), .QL(ql100), .CA(ca100), .TC(tc100));

  cnt_mod_bcd #(.MOD(60)) casc_lo (
    .CLK(clk), .RST(c_rst), .CLR(c_zero), .EN(c_en), .INC(c_zero), .DN(c_zero),
    .LD(c_zero), .DH(c_dz), .DL(c_dz), .QH(lo_qh), .QL(lo_ql), .CA(lo_ca), .TC(lo_tc));

  cnt_mod_bcd #(.MOD(24)) casc_hi (
    .CLK(clk), .RST(c_rst), .CLR(c_zero), .EN(lo_ca), .INC(c_zero), .DN(c_zero),
    .LD(c_zero), .DH(c_dz), .DL(c_dz), .QH(hi_qh), .QL(hi_ql), .CA(hi_ca), .TC(hi_tc));

  always_comb begin
    s_qh = qh60; s_ql = ql60; s_ca = ca60; s_tc = tc60;
    case (sel)
      1: begin s_qh = qh24;  s_ql = ql24;  s_ca = ca24;  s_tc = tc24;  end
      2: begin s_qh = qh100; s_ql = ql100; s_ca = ca100; s_tc = tc100; end
      default: ;
    endcase
  end

  typedef struct packed {
    logic       rst, clr, en, inc, dn, ld;
    logic [3:0] dh, dl;
    logic       ca, tc;
    logic [3:0] qh, ql;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(input logic r, input logic c, input logic e, input logic i,
                              input logic d, input logic l, input logic [3:0] h,
                              input logic [3:0] u, input logic eca, input logic etc,
                              input logic [3:0] eqh, input logic [3:0] eql);
    vec_t v;
    v.rst = r; v.clr = c; v.en = e; v.inc = i; v.dn = d; v.ld = l;
    v.dh = h; v.dl = u; v.ca = eca; v.tc = etc; v.qh = eqh; v.ql = eql;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; clr = 1'b0; en = 1'b0; inc = 1'b0; dn = 1'b0; ld = 1'b0;
    dh = 4'd0; dl = 4'd0;
    @(posedge clk); #1;
  endtask

  // One enable/inc step: flags checked before the edge, digits after it.
  task automatic step_chk(input int s, input logic e, input logic i, input logic d,
                          input int eca, input int etc, input int ecnt);
    @(negedge clk);
    sel = s; rst = 1'b1; clr = 1'b0; ld = 1'b0; en = e; inc = i; dn = d; #1;
    chk("step_ca", int'(s_ca), eca);
    chk("step_tc", int'(s_tc), etc);
    @(posedge clk); #1;
    chk("step_qh", int'(s_qh), ecnt / 10);
    chk("step_ql", int'(s_ql), ecnt % 10);
  endtask

  task automatic ld_chk(input int s, input logic [3:0] h, input logic [3:0] u, input int ecnt);
    @(negedge clk);
    sel = s; rst = 1'b1; clr = 1'b0; en = 1'b0; inc = 1'b0; dn = 1'b0;
    ld = 1'b1; dh = h; dl = u;
    @(posedge clk); #1;
    chk("ld_qh", int'(s_qh), ecnt / 10);
    chk("ld_ql", int'(s_ql), ecnt % 10);
    @(negedge clk);
    ld = 1'b0;
  endtask

  initial begin
    int cnt;
    int hi_ca_seen;
    c_zero = 1'b0; c_dz = 4'd0; c_rst = 1'b0; c_en = 1'b0;
    rst = 1'b0; clr = 1'b0; en = 1'b0; inc = 1'b0; dn = 1'b0; ld = 1'b0;
    dh = 4'd0; dl = 4'd0;

    //            rst clr en inc dn ld  dh     dl     ca   tc   qh    ql
    tbl[0]  = mk(1, 0, 1, 0, 0, 0, 4'd0, 4'd0,  0, 0, 4'd0, 4'd1);
    tbl[1]  = mk(1, 0, 0, 0, 0, 1, 4'd5, 4'd8,  0, 0, 4'd5, 4'd8);
    tbl[2]  = mk(1, 0, 1, 0, 0, 0, 4'd0, 4'd0,  0, 0, 4'd5, 4'd9);
    tbl[3]  = mk(1, 0, 1, 0, 0, 0, 4'd0, 4'd0,  1, 1, 4'd0, 4'd0);
    tbl[4]  = mk(1, 0, 1, 0, 0, 1, 4'd5, 4'd9,  0, 0, 4'd5, 4'd9);
    tbl[5]  = mk(1, 0, 0, 1, 0, 0, 4'd0, 4'd0,  0, 1, 4'd0, 4'd0);
    tbl[6]  = mk(1, 0, 0, 0, 0, 1, 4'd1, 4'd0,  0, 0, 4'd1, 4'd0);
    tbl[7]  = mk(1, 0, 1, 1, 0, 0, 4'd0, 4'd0,  0, 0, 4'd1, 4'd1);
    tbl[8]  = mk(1, 0, 0, 0, 0, 1, 4'd6, 4'd0,  0, 0, 4'd1, 4'd1);
    tbl[9]  = mk(1, 0, 1, 0, 0, 1, 4'd1, 4'hA,  0, 0, 4'd1, 4'd1);
    tbl[10] = mk(1, 0, 1, 0, 1, 0, 4'd0, 4'd0,  0, 0, 4'd1, 4'd0);
    tbl[11] = mk(1, 0, 1, 0, 1, 0, 4'd0, 4'd0,  0, 0, 4'd0, 4'd9);
    tbl[12] = mk(1, 0, 0, 0, 1, 1, 4'd0, 4'd0,  0, 0, 4'd0, 4'd0);
    tbl[13] = mk(1, 0, 1, 0, 1, 0, 4'd0, 4'd0,  1, 1, 4'd5, 4'd9);
    tbl[14] = mk(1, 0, 0, 0, 0, 0, 4'd0, 4'd0,  0, 1, 4'd5, 4'd9);
    tbl[15] = mk(1, 1, 1, 0, 0, 0, 4'd0, 4'd0,  0, 1, 4'd0, 4'd0);
    tbl[16] = mk(1, 0, 0, 0, 0, 1, 4'd5, 4'd9,  0, 0, 4'd5, 4'd9);
    tbl[17] = mk(0, 0, 1, 0, 0, 1, 4'd1, 4'd2,  0, 1, 4'd0, 4'd0);
    tbl[18] = mk(1, 0, 0, 0, 1, 0, 4'd0, 4'd0,  0, 1, 4'd0, 4'd0);
    tbl[19] = mk(1, 0, 0, 1, 1, 0, 4'd0, 4'd0,  0, 1, 4'd5, 4'd9);
    tbl[20] = mk(1, 0, 1, 0, 1, 1, 4'd2, 4'd5,  0, 0, 4'd2, 4'd5);

    // Reset state on the MOD=60 instance
    sel = 0;
    do_reset();
    chk("rst_qh", int'(qh60), 0);
    chk("rst_ql", int'(ql60), 0);
    chk("rst_ca", int'(ca60), 0);
    chk("rst_tc_up", int'(tc60), 0);
    dn = 1'b1; #1;
    chk("rst_tc_dn", int'(tc60), 1);
    dn = 1'b0;

    foreach (tbl[k]) begin
      @(negedge clk);
      rst = tbl[k].rst; clr = tbl[k].clr; en = tbl[k].en; inc = tbl[k].inc;
      dn = tbl[k].dn; ld = tbl[k].ld; dh = tbl[k].dh; dl = tbl[k].dl; #1;
      chk($sformatf("vec%0d_ca", k), int'(ca60), int'(tbl[k].ca));
      chk($sformatf("vec%0d_tc", k), int'(tc60), int'(tbl[k].tc));
      @(posedge clk); #1;
      chk($sformatf("vec%0d_qh", k), int'(qh60), int'(tbl[k].qh));
      chk($sformatf("vec%0d_ql", k), int'(ql60), int'(tbl[k].ql));
    end

    // Modulo-60 full up cycle, then full down cycle back to 00
    do_reset();
    for (int k = 0; k < 60; k++)
      step_chk(0, 1'b1, 1'b0, 1'b0, int'(k == 59), int'(k == 59), (k + 1) % 60);
    cnt = 0;
    for (int k = 0; k < 60; k++) begin
      step_chk(0, 1'b1, 1'b0, 1'b1, int'(cnt == 0), int'(cnt == 0), (cnt + 59) % 60);
      cnt = (cnt + 59) % 60;
    end
    chk("dn60_home", int'(ql60) + 10 * int'(qh60), 0);

    // Modulo-24 preset to top, wrap with carry, illegal preset ignored, full cycle
    do_reset();
    ld_chk(1, 4'd2, 4'd3, 23);
    step_chk(1, 1'b1, 1'b0, 1'b0, 1, 1, 0);
    ld_chk(1, 4'd2, 4'd4, 0);
    for (int k = 0; k < 24; k++)
      step_chk(1, 1'b1, 1'b0, 1'b0, int'(k == 23), int'(k == 23), (k + 1) % 24);
    step_chk(1, 1'b1, 1'b0, 1'b1, 1, 1, 23);

    // Modulo-100 full cycle
    do_reset();
    for (int k = 0; k < 100; k++)
      step_chk(2, 1'b1, 1'b0, 1'b0, int'(k == 99), int'(k == 99), (k + 1) % 100);

    // Cascade 60 into 24: one full day of ticks
    @(negedge clk);
    c_rst = 1'b0; c_en = 1'b1;
    @(posedge clk); #1;
    hi_ca_seen = 0;
    for (int k = 0; k < 1440; k++) begin
      @(negedge clk);
      c_rst = 1'b1; #1;
      chk("casc_lo_ca", int'(lo_ca), int'((k % 60) == 59));
      if (hi_ca) hi_ca_seen++;
      @(posedge clk); #1;
      chk("casc_lo", int'(lo_qh) * 10 + int'(lo_ql), (k + 1) % 60);
      chk("casc_hi", int'(hi_qh) * 10 + int'(hi_ql), ((k + 1) / 60) % 24);
    end
    chk("casc_hi_ca_count", hi_ca_seen, 1);
    @(negedge clk);
    c_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
